uart_tx_framer: RTL and testbench

Parametrised UART transmit framer that generalises the team's fixed 8-bit LSB-first PISO with parity. It accepts a parallel word over a valid/ready handshake and serialises a full frame: start bit, W_DATA data bits, optional parity bit, and N_STOP stop bits. Bit timing comes from an external one-clock baud_tick strobe. It sits between the TX data source (FIFO or controller) and the UART tx pin.

---
 rtl/uart_tx_framer.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_framer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// +-----------------------------------------------------------------------------
// | uart_tx_framer: parametrised UART transmit framer (start, data, parity, stop)
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module uart_tx_framer #(
  parameter int W_DATA    = 8,
  parameter int N_STOP    = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_DATA-1:0] in_data,
  input  logic [1:0]        parity_mode,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(W_DATA);
  localparam logic [CW-1:0] c_last_bit  = CW'(W_DATA - 1);
  localparam logic          c_last_stop = 1'(N_STOP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [W_DATA-1:0] r_shreg, w_shreg_nxt, w_shifted;
  logic [CW-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic              r_stop_cnt, w_stop_cnt_nxt;
  logic              r_par, w_par_nxt;
  logic              r_par_en, w_par_en_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_done, w_done_nxt;
  logic              w_first_bit, w_next_bit;

  // The output end of the shift register depends on bit order.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted   = {r_shreg[W_DATA-2:0], 1'b0};
      assign w_first_bit = r_shreg[W_DATA-1];
      assign w_next_bit  = r_shreg[W_DATA-2];
    end else begin : g_lsb_first
      assign w_shifted   = {1'b0, r_shreg[W_DATA-1:1]};
      assign w_first_bit = r_shreg[0];
      assign w_next_bit  = r_shreg[1];
    end
  endgenerate

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_par_nxt      = r_par;
    w_par_en_nxt   = r_par_en;
    w_tx_nxt       = r_tx;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (in_valid) begin
          w_state_nxt  = S_ARM;
          w_shreg_nxt  = in_data;
          w_par_en_nxt = |parity_mode;
          case (parity_mode)
            2'd2:    w_par_nxt = ~(^in_data);
            2'd3:    w_par_nxt = 1'b1;
            default: w_par_nxt = ^in_data;
          endcase
        end
      end
      S_ARM: begin
        if (baud_tick) begin
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          w_state_nxt   = S_DATA;
          w_tx_nxt      = w_first_bit;
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (r_bit_cnt == c_last_bit) begin
            w_stop_cnt_nxt = 1'b0;
            if (r_par_en) begin
              w_state_nxt = S_PAR;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_shreg_nxt   = w_shifted;
            w_tx_nxt      = w_next_bit;
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (baud_tick) begin
          w_state_nxt    = S_STOP;
          w_tx_nxt       = 1'b1;
          w_stop_cnt_nxt = 1'b0;
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (baud_tick) begin
          if (r_stop_cnt == c_last_stop) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_par      <= w_par_nxt;
      r_par_en   <= w_par_en_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign tx       = r_tx;
  assign done     = r_done;
  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
// +-----------------------------------------------------------------------------
// | tb_uart_tx_framer: directed bench for three uart_tx_framer configurations
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [7:0] in_data;
  logic [1:0] parity_mode;
  logic [2:0] vv;
  wire  [2:0] txv, rdyv, busyv, donev;
  int         sel;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults, 1: two stop bits, 2: MSB first.
  uart_tx_framer #(.W_DATA(8), .N_STOP(1), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_valid(vv[0]), .in_ready(rdyv[0]),
    .in_data(in_data), .parity_mode(parity_mode), .tx(txv[0]), .busy(busyv[0]), .done(donev[0]));
  uart_tx_framer #(.W_DATA(8), .N_STOP(2), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_valid(vv[1]), .in_ready(rdyv[1]),
    .in_data(in_data), .parity_mode(parity_mode), .tx(txv[1]), .busy(busyv[1]), .done(donev[1]));
  uart_tx_framer #(.W_DATA(8), .N_STOP(1), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_valid(vv[2]), .in_ready(rdyv[2]),
    .in_data(in_data), .parity_mode(parity_mode), .tx(txv[2]), .busy(busyv[2]), .done(donev[2]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut=%0d observed=%b expected=%b", tag, sel, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic etx, input logic erdy,
                         input logic ebusy, input logic edone);
    chk({tag, ".tx"}, txv[sel], etx);
    chk({tag, ".in_ready"}, rdyv[sel], erdy);
    chk({tag, ".busy"}, busyv[sel], ebusy);
    chk({tag, ".done"}, donev[sel], edone);
  endtask

  task automatic clk1(input logic tk);
    baud_tick = tk;
    @(posedge clk);
    #1;
    baud_tick = 1'b0;
  endtask

  // bits: transmitted order is from bit n-1 down to bit 0; one done tick follows.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      clk1(1'b1);
      chk_out($sformatf("%s.bit%0d", tag, n - 1 - i), bits[i], 1'b0, 1'b1, 1'b0);
      for (int g = 0; g < gap; g++) clk1(1'b0);
      if (gap > 0) chk($sformatf("%s.hold%0d", tag, n - 1 - i), txv[sel], bits[i]);
    end
    clk1(1'b1);
    chk_out({tag, ".end"}, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic accept(input int s, input logic [7:0] d, input logic [1:0] m, input logic tk);
    sel = s;
    in_data = d;
    parity_mode = m;
    vv = 3'b000;
    vv[s] = 1'b1;
    clk1(tk);
  endtask

  initial begin
    rst = 1'b0;
    baud_tick = 1'b0;
    in_data = '0;
    parity_mode = '0;
    vv = '0;
    sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      chk_out("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b1;

    // 1: idle with ticks
    for (int c = 0; c < 20; c++) begin
      clk1((c % 4) == 0);
      for (int s = 0; s < 3; s++) begin
        sel = s;
        chk_out("idle", 1'b1, 1'b1, 1'b0, 1'b0);
      end
    end

    // 2: 0xA5 even, tick in the accept cycle, inputs changed after accept
    accept(0, 8'hA5, 2'd1, 1'b1);
    vv = '0;
    in_data = 8'hFF;
    parity_mode = 2'd2;
    chk_out("t2.arm", 1'b1, 1'b0, 1'b1, 1'b0);
    clk1(1'b0);
    chk_out("t2.arm2", 1'b1, 1'b0, 1'b1, 1'b0);
    run_frame("t2", 16'b01010010101, 11, 3);
    clk1(1'b0);
    chk_out("t2.after", 1'b1, 1'b1, 1'b0, 1'b0);

    // 3: two stop bits, 0x00 odd then none
    accept(1, 8'h00, 2'd2, 1'b0);
    vv = '0;
    chk_out("t3.arm", 1'b1, 1'b0, 1'b1, 1'b0);
    run_frame("t3odd", 16'b000000000111, 12, 3);
    clk1(1'b0);
    accept(1, 8'h00, 2'd0, 1'b0);
    vv = '0;
    run_frame("t3none", 16'b00000000011, 11, 3);
    clk1(1'b0);

    // 4: MSB first, 0x01 none; then mark with baud_tick held high continuously
    accept(2, 8'h01, 2'd0, 1'b0);
    vv = '0;
    run_frame("t4none", 16'b0000000011, 10, 3);
    clk1(1'b0);
    accept(2, 8'h01, 2'd3, 1'b0);
    vv = '0;
    run_frame("t4mark", 16'b00000000111, 11, 0);
    clk1(1'b0);
    chk_out("t4.after", 1'b1, 1'b1, 1'b0, 1'b0);

    // 5: in_valid held, data changed mid-frame, back-to-back accept in the done cycle
    accept(0, 8'h3C, 2'd1, 1'b0);
    in_data = 8'hC3;
    run_frame("t5a", 16'b00011110001, 11, 3);
    clk1(1'b0);
    chk_out("t5.b2b", 1'b1, 1'b0, 1'b1, 1'b0);
    vv = '0;
    run_frame("t5b", 16'b01100001101, 11, 3);
    clk1(1'b0);

    // 6: reset during the 4th data bit
    accept(0, 8'h00, 2'd0, 1'b0);
    vv = '0;
    for (int k = 0; k < 4; k++) begin
      clk1(1'b1);
      repeat (3) clk1(1'b0);
    end
    clk1(1'b1);
    chk("t6.bit3", txv[0], 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_out("t6.async", 1'b1, 1'b1, 1'b0, 1'b0);
    clk1(1'b1);
    clk1(1'b0);
    chk_out("t6.inrst", 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      clk1(1'b1);
      chk_out("t6.quiet", 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (3) clk1(1'b0);
    end
    accept(0, 8'h55, 2'd1, 1'b0);
    vv = '0;
    run_frame("t6", 16'b01010101001, 11, 3);
    clk1(1'b0);
    chk_out("t6.after", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
